fir_cfg_ctrl: RTL and testbench

// - AXI-Lite configuration and control front end for the FIR engine: holds ap_ctrl and data_length.
// - Arbitrates the single-port tap BRAM (bram11) between AXI-Lite tap accesses and the FIR engine.
// - Sequences engine start and done, and reports ap_start/ap_done/ap_idle to the host.

---
 rtl/fir_cfg_ctrl.sv | 279 +++++++++++++++++++++++++++
 tb/tb_fir_cfg_ctrl.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_cfg_ctrl.sv
// -----------------------------------------------------------------------------
// fir_cfg_ctrl
// AXI-Lite configuration / control front end for the FIR engine.
//   - Holds ap_ctrl (start/done/idle) and data_length.
//   - Arbitrates the single-port tap BRAM between AXI-Lite and the engine.
//   - Sequences engine start and done.
//
// Ports
//   axis_clk, axis_rst_n          clock, asynchronous active-low reset
//   aw*/w*                        AXI-Lite write address/data (no response channel)
//   ar*/r*                        AXI-Lite read address/data
//   tap_WE/EN/Di/A, tap_Do        tap BRAM port (1-cycle read latency)
//   eng_start                     one-cycle engine launch pulse
//   eng_done                      one-cycle engine completion pulse
//   eng_tap_EN/eng_tap_A          engine tap read request (byte address)
//   eng_tap_Do                    tap data returned to the engine
//   cfg_len                       data_length register
//   irq                           interrupt, present only with FIR_CFG_IRQ_EN
//
// Optional feature macro: FIR_CFG_IRQ_EN adds register 0x04 (bit0 irq_en)
// and the irq output. Without it 0x04 reads 0 and writes are dropped.
//
// Register map
//   0x00  ap_ctrl      bit0 start, bit1 done (clear on read), bit2 idle
//   0x04  irq_en       bit0 (FIR_CFG_IRQ_EN only)
//   0x10  data_length  writable only while idle
//   0x80+ tap window   0x80 .. 0x80+4*(Tape_Num-1)
//
// State | meaning
// ------+------------------------------------------------------------------
// IDLE  | AXI-Lite owns the tap port; a start write launches the engine
// START | single cycle, eng_start asserted, ap_idle already low
// BUSY  | engine owns the tap port; waits for eng_done
// -----------------------------------------------------------------------------
module fir_cfg_ctrl #(
   parameter int pADDR_WIDTH = 12,
   parameter int pDATA_WIDTH = 32,
   parameter int Tape_Num    = 11
) (
   input  logic                   axis_clk,
   input  logic                   axis_rst_n,
   input  logic                   awvalid,
   output logic                   awready,
   input  logic [pADDR_WIDTH-1:0] awaddr,
   input  logic                   wvalid,
   output logic                   wready,
   input  logic [pDATA_WIDTH-1:0] wdata,
   input  logic                   arvalid,
   output logic                   arready,
   input  logic [pADDR_WIDTH-1:0] araddr,
   output logic                   rvalid,
   input  logic                   rready,
   output logic [pDATA_WIDTH-1:0] rdata,
   output logic [3:0]             tap_WE,
   output logic                   tap_EN,
   output logic [pDATA_WIDTH-1:0] tap_Di,
   output logic [pADDR_WIDTH-1:0] tap_A,
   input  logic [pDATA_WIDTH-1:0] tap_Do,
   output logic                   eng_start,
   input  logic                   eng_done,
   input  logic                   eng_tap_EN,
   input  logic [pADDR_WIDTH-1:0] eng_tap_A,
   output logic [pDATA_WIDTH-1:0] eng_tap_Do,
`ifdef FIR_CFG_IRQ_EN
   output logic                   irq,
`endif
   output logic [pDATA_WIDTH-1:0] cfg_len
);

   localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = '0;
   localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'(16);
   localparam logic [pADDR_WIDTH-1:0] TAP_BASE  = pADDR_WIDTH'(128);
   localparam logic [pADDR_WIDTH-1:0] TAP_LAST  = pADDR_WIDTH'(128 + 4 * (Tape_Num - 1));
`ifdef FIR_CFG_IRQ_EN
   localparam logic [pADDR_WIDTH-1:0] ADDR_IRQ  = pADDR_WIDTH'(4);
`endif

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_BUSY  = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic                   aw_ack_q, aw_ack_d;
   logic                   ar_ack_q, ar_ack_d;
   logic                   rvalid_q, rvalid_d;
   logic [pDATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                   rd_tap_q, rd_tap_d;
   logic                   ap_start_q, ap_start_d;
   logic                   ap_done_q, ap_done_d;
   logic                   ap_idle_q, ap_idle_d;
   logic                   eng_start_q, eng_start_d;
   logic [pDATA_WIDTH-1:0] len_q, len_d;
`ifdef FIR_CFG_IRQ_EN
   logic                   irq_en_q, irq_en_d;
   logic                   irq_q, irq_d;
`endif

   logic                   wr_fire;
   logic                   rd_fire;
   logic                   idle_st;
   logic                   aw_tap;
   logic                   ar_tap;
   logic [pDATA_WIDTH-1:0] rd_reg;

   function automatic logic tap_hit(input logic [pADDR_WIDTH-1:0] a);
      return (a >= TAP_BASE) && (a <= TAP_LAST);
   endfunction

   // A transfer completes in the cycle the registered ready is high while
   // the master still presents valid.
   assign wr_fire = aw_ack_q & awvalid & wvalid;
   assign rd_fire = ar_ack_q & arvalid;
   assign idle_st = (state_q == S_IDLE);
   assign aw_tap  = tap_hit(awaddr);
   assign ar_tap  = tap_hit(araddr);

   // Register read mux; tap addresses outside IDLE fall through to 0.
   always_comb begin
      rd_reg = '0;
      if (araddr == ADDR_CTRL) begin
         rd_reg = pDATA_WIDTH'({ap_idle_q, ap_done_q, ap_start_q});
      end else if (araddr == ADDR_LEN) begin
         rd_reg = len_q;
`ifdef FIR_CFG_IRQ_EN
      end else if (araddr == ADDR_IRQ) begin
         rd_reg = pDATA_WIDTH'(irq_en_q);
`endif
      end
   end

   always_comb begin
      // Handshakes. A pending write acknowledge holds off a read accept,
      // so a simultaneous aw+w and ar commits the write first.
      aw_ack_d = awvalid & wvalid & ~aw_ack_q;
      ar_ack_d = arvalid & ~ar_ack_q & ~rvalid_q & ~rd_tap_q & ~aw_ack_d;

      // Read data path
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      rd_tap_d = 1'b0;
      if (rvalid_q && rready) begin
         rvalid_d = 1'b0;
      end
      if (rd_tap_q) begin
         rvalid_d = 1'b1;
         rdata_d  = tap_Do;
      end
      if (rd_fire) begin
         if (idle_st && ar_tap) begin
            rd_tap_d = 1'b1;
         end else begin
            rvalid_d = 1'b1;
            rdata_d  = rd_reg;
         end
      end

      // Control FSM
      state_d     = state_q;
      ap_start_d  = ap_start_q;
      ap_done_d   = ap_done_q;
      ap_idle_d   = ap_idle_q;
      eng_start_d = 1'b0;
      len_d       = len_q;

      // Clear-on-read comes first so a coincident eng_done wins.
      if (rd_fire && (araddr == ADDR_CTRL)) begin
         ap_done_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (wr_fire && (awaddr == ADDR_CTRL) && wdata[0]) begin
               state_d     = S_START;
               ap_start_d  = 1'b1;
               ap_done_d   = 1'b0;
               ap_idle_d   = 1'b0;
               eng_start_d = 1'b1;
            end
            if (wr_fire && (awaddr == ADDR_LEN)) begin
               len_d = wdata;
            end
         end
         S_START: begin
            state_d    = S_BUSY;
            ap_start_d = 1'b0;
         end
         S_BUSY: begin
            if (eng_done) begin
               state_d   = S_IDLE;
               ap_done_d = 1'b1;
               ap_idle_d = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

`ifdef FIR_CFG_IRQ_EN
      irq_en_d = irq_en_q;
      if (wr_fire && (awaddr == ADDR_IRQ)) begin
         irq_en_d = wdata[0];
      end
      irq_d = ap_done_d & irq_en_d;
`endif
   end

   // Tap port: the engine owns it whenever a run is in progress; otherwise
   // only an AXI tap write/read in its transfer cycle touches the BRAM.
   always_comb begin
      tap_EN = 1'b0;
      tap_WE = 4'h0;
      tap_A  = '0;
      tap_Di = '0;
      if (!idle_st) begin
         tap_EN = eng_tap_EN;
         tap_A  = eng_tap_A;
      end else if (wr_fire && aw_tap) begin
         tap_EN = 1'b1;
         tap_WE = 4'hF;
         tap_A  = awaddr - TAP_BASE;
         tap_Di = wdata;
      end else if (rd_fire && ar_tap) begin
         tap_EN = 1'b1;
         tap_A  = araddr - TAP_BASE;
      end
   end

   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         state_q     <= S_IDLE;
         aw_ack_q    <= 1'b0;
         ar_ack_q    <= 1'b0;
         rvalid_q    <= 1'b0;
         rdata_q     <= '0;
         rd_tap_q    <= 1'b0;
         ap_start_q  <= 1'b0;
         ap_done_q   <= 1'b0;
         ap_idle_q   <= 1'b1;
         eng_start_q <= 1'b0;
         len_q       <= '0;
`ifdef FIR_CFG_IRQ_EN
         irq_en_q    <= 1'b0;
         irq_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         aw_ack_q    <= aw_ack_d;
         ar_ack_q    <= ar_ack_d;
         rvalid_q    <= rvalid_d;
         rdata_q     <= rdata_d;
         rd_tap_q    <= rd_tap_d;
         ap_start_q  <= ap_start_d;
         ap_done_q   <= ap_done_d;
         ap_idle_q   <= ap_idle_d;
         eng_start_q <= eng_start_d;
         len_q       <= len_d;
`ifdef FIR_CFG_IRQ_EN
         irq_en_q    <= irq_en_d;
         irq_q       <= irq_d;
`endif
      end
   end

   assign awready    = aw_ack_q;
   assign wready     = aw_ack_q;
   assign arready    = ar_ack_q;
   assign rvalid     = rvalid_q;
   assign rdata      = rdata_q;
   assign eng_start  = eng_start_q;
   assign eng_tap_Do = tap_Do;
   assign cfg_len    = len_q;
`ifdef FIR_CFG_IRQ_EN
   assign irq        = irq_q;
`endif

endmodule

// File: tb/tb_fir_cfg_ctrl.sv
// Bench for fir_cfg_ctrl: table-driven register/tap vectors, hand-written
// sequences for start/busy/done/reset corners, and a randomized phase
// checked against a simple register/tap model. Holds its own tap BRAM.
module tb_fir_cfg_ctrl;

   localparam int TAPS = 11;

   logic        axis_clk = 1'b0;
   logic        axis_rst_n;
   logic        awvalid, awready, wvalid, wready;
   logic [11:0] awaddr;
   logic [31:0] wdata;
   logic        arvalid, arready, rvalid, rready;
   logic [11:0] araddr;
   logic [31:0] rdata;
   logic [3:0]  tap_WE;
   logic        tap_EN;
   logic [31:0] tap_Di;
   logic [11:0] tap_A;
   logic [31:0] tap_Do;
   logic        eng_start, eng_done, eng_tap_EN;
   logic [11:0] eng_tap_A;
   logic [31:0] eng_tap_Do;
   logic [31:0] cfg_len;
`ifdef FIR_CFG_IRQ_EN
   logic        irq;
`endif

   fir_cfg_ctrl dut (
      .axis_clk   (axis_clk),
      .axis_rst_n (axis_rst_n),
      .awvalid    (awvalid),
      .awready    (awready),
      .awaddr     (awaddr),
      .wvalid     (wvalid),
      .wready     (wready),
      .wdata      (wdata),
      .arvalid    (arvalid),
      .arready    (arready),
      .araddr     (araddr),
      .rvalid     (rvalid),
      .rready     (rready),
      .rdata      (rdata),
      .tap_WE     (tap_WE),
      .tap_EN     (tap_EN),
      .tap_Di     (tap_Di),
      .tap_A      (tap_A),
      .tap_Do     (tap_Do),
      .eng_start  (eng_start),
      .eng_done   (eng_done),
      .eng_tap_EN (eng_tap_EN),
      .eng_tap_A  (eng_tap_A),
      .eng_tap_Do (eng_tap_Do),
`ifdef FIR_CFG_IRQ_EN
      .irq        (irq),
`endif
      .cfg_len    (cfg_len)
   );

   always #5 axis_clk = ~axis_clk;

   // Single-port tap BRAM, 1-cycle read latency
   logic [31:0] bram [0:63];
   always @(posedge axis_clk) begin
      if (tap_EN) begin
         if (tap_WE == 4'hF) bram[tap_A[7:2]] <= tap_Di;
         tap_Do <= bram[tap_A[7:2]];
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic axi_write(input logic [11:0] a, input logic [31:0] d,
                            output logic [3:0] we, output logic [11:0] ta);
      int n;
      @(negedge axis_clk);
      awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
      n = 0;
      do begin @(negedge axis_clk); n++; end while (!awready && n < 50);
      check("awready", 32'(awready), 32'd1);
      check("wready", 32'(wready), 32'd1);
      we = tap_WE;
      ta = tap_A;
      @(negedge axis_clk);
      awvalid = 1'b0; wvalid = 1'b0;
   endtask

   task automatic axi_read(input logic [11:0] a, output logic [31:0] d, output int lat);
      int n;
      @(negedge axis_clk);
      araddr = a; arvalid = 1'b1;
      n = 0;
      do begin @(negedge axis_clk); n++; end while (!arready && n < 50);
      check("arready", 32'(arready), 32'd1);
      @(negedge axis_clk);
      arvalid = 1'b0;
      lat = 1;
      while (!rvalid && lat < 50) begin @(negedge axis_clk); lat++; end
      check("rvalid", 32'(rvalid), 32'd1);
      d = rdata;
      rready = 1'b1;
      @(negedge axis_clk);
      rready = 1'b0;
   endtask

   task automatic pulse_done();
      @(negedge axis_clk);
      eng_done = 1'b1;
      @(negedge axis_clk);
      eng_done = 1'b0;
   endtask

   typedef struct {
      bit          wr;
      logic [11:0] addr;
      logic [31:0] data;
      logic [31:0] exp;   // read data, or tap_WE seen on a write
      int          lat;
   } vec_t;

   vec_t        vecs[$];
   int          coef [TAPS] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
   logic [31:0] model_tap [TAPS];
   logic [31:0] model_len;
   logic [11:0] unmapped[$];

   function automatic void add_vec(bit wr, logic [11:0] a, logic [31:0] d, logic [31:0] e, int l);
      vec_t v;
      v.wr = wr; v.addr = a; v.data = d; v.exp = e; v.lat = l;
      vecs.push_back(v);
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic [31:0] v;
      logic [3:0]  we;
      logic [11:0] ta;
      logic [11:0] ua;
      int          lat, k, op, n;
      bit          ok;

      axis_rst_n = 1'b0;
      awvalid = 0; wvalid = 0; arvalid = 0; rready = 0;
      awaddr = '0; wdata = '0; araddr = '0;
      eng_done = 0; eng_tap_EN = 0; eng_tap_A = '0;
      unmapped = '{12'h008, 12'h00C, 12'h014, 12'h020, 12'h07C, 12'h0AC, 12'h0B0, 12'hFFC};
`ifndef FIR_CFG_IRQ_EN
      unmapped.push_back(12'h004);
`endif

      // ---- reset values ----
      repeat (3) @(negedge axis_clk);
      check("rst_awready", 32'(awready), 0);
      check("rst_arready", 32'(arready), 0);
      check("rst_rvalid", 32'(rvalid), 0);
      check("rst_rdata", rdata, 0);
      check("rst_tap_en_we", {27'b0, tap_EN, tap_WE}, 0);
      check("rst_eng_start", 32'(eng_start), 0);
      check("rst_cfg_len", cfg_len, 0);
      axis_rst_n = 1'b1;

      // ---- table-driven vectors ----
      add_vec(0, 12'h000, 0, 32'h4, 1);
      for (int i = 0; i < TAPS; i++) add_vec(1, 12'(12'h080 + 4 * i), 32'(coef[i]), 32'hF, 0);
      for (int i = 0; i < TAPS; i++) add_vec(0, 12'(12'h080 + 4 * i), 0, 32'(coef[i]), 2);
      add_vec(1, 12'h010, 32'd600, 32'h0, 0);
      add_vec(0, 12'h010, 0, 32'd600, 1);
      add_vec(0, 12'h0AC, 0, 32'h0, 1);
      add_vec(0, 12'h07C, 0, 32'h0, 1);
      add_vec(1, 12'h0AC, 32'h1234, 32'h0, 0);

      foreach (vecs[i]) begin
         if (vecs[i].wr) begin
            axi_write(vecs[i].addr, vecs[i].data, we, ta);
            check($sformatf("vec%0d_we", i), 32'(we), vecs[i].exp);
         end else begin
            axi_read(vecs[i].addr, rd, lat);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
         end
      end
      for (int i = 0; i < TAPS; i++) model_tap[i] = 32'(coef[i]);
      model_len = 32'd600;
      check("cfg_len_600", cfg_len, 32'd600);

      // ---- write and read in the same cycle: write commits first ----
      @(negedge axis_clk);
      awaddr = 12'h010; wdata = 32'd77; araddr = 12'h010;
      awvalid = 1; wvalid = 1; arvalid = 1;
      @(negedge axis_clk);
      check("wr_first_awready", 32'(awready), 1);
      check("wr_first_arready", 32'(arready), 0);
      @(negedge axis_clk);
      awvalid = 0; wvalid = 0;
      check("rd_next_arready", 32'(arready), 1);
      @(negedge axis_clk);
      arvalid = 0;
      check("rd_after_wr_rvalid", 32'(rvalid), 1);
      check("rd_after_wr_rdata", rdata, 32'd77);
      rready = 1; @(negedge axis_clk); rready = 0;

      // ---- rvalid/rdata hold until rready; no new ar meanwhile ----
      araddr = 12'h010; arvalid = 1;
      n = 0;
      do begin @(negedge axis_clk); n++; end while (!arready && n < 50);
      check("hold_arready", 32'(arready), 1);
      @(negedge axis_clk);
      araddr = 12'h000;
      ok = 1;
      repeat (4) begin
         if (!(rvalid && rdata == 32'd77 && !arready)) ok = 0;
         @(negedge axis_clk);
      end
      check("rvalid_hold", 32'(ok), 1);
      rready = 1; @(negedge axis_clk); rready = 0;
      check("rvalid_drop", 32'(rvalid), 0);
      n = 0;
      while (!arready && n < 50) begin @(negedge axis_clk); n++; end
      check("hold_next_arready", 32'(arready), 1);
      @(negedge axis_clk);
      arvalid = 0;
      check("hold_next_rdata", rdata, 32'h4);
      rready = 1; @(negedge axis_clk); rready = 0;

      axi_write(12'h010, 32'd600, we, ta);

`ifdef FIR_CFG_IRQ_EN
      axi_write(12'h004, 32'h1, we, ta);
      axi_read(12'h004, rd, lat);
      check("irq_en_rd", rd, 32'h1);
`endif

      // ---- start a run ----
      axi_write(12'h000, 32'h1, we, ta);
      check("eng_start_pulse", 32'(eng_start), 1);
      @(negedge axis_clk);
      check("eng_start_end", 32'(eng_start), 0);
      check("busy_cfg_len", cfg_len, 32'd600);
      axi_read(12'h000, rd, lat);
      check("busy_ctrl", rd, 32'h0);

      // AXI tap access while the engine owns the port
      axi_write(12'h084, 32'd7, we, ta);
      check("busy_tap_we", 32'(we), 0);
      axi_read(12'h084, rd, lat);
      check("busy_tap_rd", rd, 32'h0);
      check("busy_tap_lat", 32'(lat), 1);
      check("busy_tap_ram", bram[1], 32'hFFFF_FFF6);

      for (int i = 0; i < TAPS; i++) begin
         @(negedge axis_clk);
         eng_tap_EN = 1; eng_tap_A = 12'(4 * i);
         @(negedge axis_clk);
         eng_tap_EN = 0;
         check($sformatf("eng_tap%0d", i), eng_tap_Do, model_tap[i]);
      end

      // start and data_length writes are ignored while busy
      axi_write(12'h000, 32'h1, we, ta);
      check("busy_restart", 32'(eng_start), 0);
      axi_write(12'h010, 32'd5, we, ta);
      check("busy_len_write", cfg_len, 32'd600);

      pulse_done();
`ifdef FIR_CFG_IRQ_EN
      check("irq_set", 32'(irq), 1);
`endif
      axi_read(12'h000, rd, lat);
      check("done_ctrl_first", rd, 32'h6);
      axi_read(12'h000, rd, lat);
      check("done_ctrl_second", rd, 32'h4);
`ifdef FIR_CFG_IRQ_EN
      check("irq_clr", 32'(irq), 0);
`endif

      // ---- eng_done coincident with the clearing read ----
      axi_write(12'h000, 32'h1, we, ta);
      @(negedge axis_clk);
      araddr = 12'h000; arvalid = 1;
      n = 0;
      do begin @(negedge axis_clk); n++; end while (!arready && n < 50);
      check("race_arready", 32'(arready), 1);
      eng_done = 1;
      @(negedge axis_clk);
      eng_done = 0; arvalid = 0;
      check("race_rvalid", 32'(rvalid), 1);
      check("race_rdata", rdata, 32'h0);
      rready = 1; @(negedge axis_clk); rready = 0;
      axi_read(12'h000, rd, lat);
      check("race_next", rd, 32'h6);
      axi_read(12'h000, rd, lat);
      check("race_clear", rd, 32'h4);

      // ---- randomized idle traffic against the model ----
      for (int i = 0; i < 60; i++) begin
         op = $urandom_range(0, 6);
         k  = $urandom_range(0, TAPS - 1);
         v  = $urandom;
         case (op)
            0: begin
               axi_write(12'(12'h080 + 4 * k), v, we, ta);
               model_tap[k] = v;
               check("rnd_tap_we", 32'(we), 32'hF);
               check("rnd_tap_a", 32'(ta), 32'(4 * k));
            end
            1: begin
               axi_read(12'(12'h080 + 4 * k), rd, lat);
               check("rnd_tap_rd", rd, model_tap[k]);
               check("rnd_tap_lat", 32'(lat), 2);
            end
            2: begin
               axi_write(12'h010, v, we, ta);
               model_len = v;
               check("rnd_len_out", cfg_len, model_len);
            end
            3: begin
               axi_read(12'h010, rd, lat);
               check("rnd_len_rd", rd, model_len);
               check("rnd_len_lat", 32'(lat), 1);
            end
            4: begin
               ua = unmapped[$urandom_range(0, unmapped.size() - 1)];
               axi_write(ua, v, we, ta);
               check("rnd_unm_we", 32'(we), 0);
               check("rnd_unm_len", cfg_len, model_len);
            end
            5: begin
               ua = unmapped[$urandom_range(0, unmapped.size() - 1)];
               axi_read(ua, rd, lat);
               check("rnd_unm_rd", rd, 0);
            end
            default: begin
               axi_write(12'h000, v & 32'hFFFF_FFFE, we, ta);
               axi_read(12'h000, rd, lat);
               check("rnd_ctrl_nostart", rd, 32'h4);
            end
         endcase
      end

      // ---- engine reads of the randomized taps ----
      axi_write(12'h000, 32'h1, we, ta);
      check("rnd_start", 32'(eng_start), 1);
      for (int i = 0; i < 20; i++) begin
         k = $urandom_range(0, TAPS - 1);
         @(negedge axis_clk);
         eng_tap_EN = 1; eng_tap_A = 12'(4 * k);
         @(negedge axis_clk);
         eng_tap_EN = 0;
         check("rnd_eng_tap", eng_tap_Do, model_tap[k]);
      end

      // ---- reset in the middle of a run ----
      @(negedge axis_clk);
      eng_tap_EN = 1; eng_tap_A = 12'h008;
      #1;
      check("busy_tap_en", 32'(tap_EN), 1);
      axis_rst_n = 0;
      #1;
      check("mid_rst_tap_en", 32'(tap_EN), 0);
      check("mid_rst_cfg_len", cfg_len, 0);
      check("mid_rst_hs", {28'b0, awready, wready, arready, rvalid}, 0);
      check("mid_rst_eng_start", 32'(eng_start), 0);
      @(negedge axis_clk);
      eng_tap_EN = 0;
      axis_rst_n = 1;
      axi_read(12'h000, rd, lat);
      check("post_rst_ctrl", rd, 32'h4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
